// File: rtl/w_icons_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w_icons_spi_pkg
//  Description : Shared defaults, frame bit positions and FSM state encoding
//                for the oversampling SPI configuration slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package w_icons_spi_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 8;
    localparam int FRAME_W_DEF = 1 + ADDR_W_DEF + DATA_W_DEF;

    // Bit positions inside a default-sized frame (MSB first on the wire)
    localparam int RW_BIT   = FRAME_W_DEF - 1;
    localparam int ADDR_LSB = DATA_W_DEF;

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_ADDR      = 2'd2,
        S_DATA      = 2'd3
    } spi_state_t;

endpackage : w_icons_spi_pkg
`default_nettype wire

// File: rtl/w_icons_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : w_icons_sync_ff
//  Description : Multi-stage flip-flop synchroniser for one asynchronous pad
//                input, with a selectable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module w_icons_sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_ref_i,
    input  logic reset_i,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : w_icons_sync_ff
`default_nettype wire

// File: rtl/w_icons_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : w_icons_spi_slave
//  Description : Oversampling SPI mode-0 slave. Synchronises the raw pad
//                lines, decodes 16-bit R/W + address + data frames and issues
//                single-cycle register-file write/read strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module w_icons_spi_slave
    import w_icons_spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_ref_i,
    input  logic              reset_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              frame_err_o
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int SET_W   = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] c_HDR_LAST   = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] c_FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] c_FRAME_LEN  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(FRAME_W + 1);
    localparam logic [SET_W-1:0] c_SETTLE     = SET_W'(SYNC_STAGES + 1);

    // ---------------- synchronisers and edge detection ----------------
    logic w_sck_s, w_cs_s, w_mosi_s;
    logic r_sck_d, r_cs_d;

    w_icons_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_ref_i (clk_ref_i),
        .reset_i   (reset_i),
        .i_d       (spi_clk_i),
        .o_q       (w_sck_s)
    );

    w_icons_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_ref_i (clk_ref_i),
        .reset_i   (reset_i),
        .i_d       (spi_cs_i),
        .o_q       (w_cs_s)
    );

    w_icons_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_ref_i (clk_ref_i),
        .reset_i   (reset_i),
        .i_d       (spi_mosi_i),
        .o_q       (w_mosi_s)
    );

    // Delay the synchronised SCK and CS by one cycle for edge detection
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            r_sck_d <= 1'b0;
            r_cs_d  <= 1'b1;
        end else begin
            r_sck_d <= w_sck_s;
            r_cs_d  <= w_cs_s;
        end
    end

    logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
    assign w_cs_rise  =  w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s &  r_cs_d;
    // A CS rise wins over a coincident SCK edge
    assign w_sck_rise =  w_sck_s & ~r_sck_d & ~w_cs_rise;
    assign w_sck_fall = ~w_sck_s &  r_sck_d & ~w_cs_rise;

    // ---------------- post-reset settle ----------------
    // The CS synchroniser comes out of reset reading "high" regardless of the
    // pad, so WAIT_IDLE only trusts it once the chain has refilled.
    logic [SET_W-1:0] r_settle;
    logic             w_settled;
    assign w_settled = (r_settle == c_SETTLE);

    // Count cycles since reset until the synchroniser holds real pad values
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + 1'b1;
        end
    end

    // ---------------- FSM ----------------
    spi_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    // State register
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_IDLE: if (w_settled && w_cs_s) w_state_nxt = S_IDLE;
            S_IDLE:      if (w_cs_fall)           w_state_nxt = S_ADDR;
            S_ADDR: begin
                if (w_cs_rise)                                 w_state_nxt = S_IDLE;
                else if (w_sck_rise && (r_cnt == c_HDR_LAST))  w_state_nxt = S_DATA;
            end
            S_DATA:      if (w_cs_rise)           w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [FRAME_W-1:0] r_rx;
    logic [FRAME_W-1:0] w_rx_next;
    logic [DATA_W-1:0]  r_tx;
    logic               r_is_read;
    logic               r_rd_d;
    logic               r_miso, r_wr, r_rd, r_err;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;

    assign w_rx_next = {r_rx[FRAME_W-2:0], w_mosi_s};

    // Shift register, bit counter, strobes, read-data capture and MISO
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_rd_d    <= 1'b0;
            r_miso    <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_err  <= 1'b0;
            r_rd_d <= r_rd;

            // Register bank answers within one cycle of the read strobe
            if (r_rd_d) begin
                r_tx <= reg_rdata_i;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_cnt     <= '0;
                        r_rx      <= '0;
                        r_is_read <= 1'b0;
                        r_miso    <= 1'b0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (w_cs_rise) begin
                        r_err  <= (r_cnt != c_FRAME_LEN);
                        r_miso <= 1'b0;
                    end else begin
                        if (w_sck_rise) begin
                            // Bits past the end of the frame are ignored
                            if (r_cnt < c_FRAME_LEN) r_rx  <= w_rx_next;
                            if (r_cnt < c_CNT_MAX)   r_cnt <= r_cnt + 1'b1;

                            if ((r_state == S_ADDR) && (r_cnt == c_HDR_LAST)) begin
                                r_is_read <= ~w_rx_next[ADDR_W];
                                if (!w_rx_next[ADDR_W]) begin
                                    r_rd   <= 1'b1;
                                    r_addr <= w_rx_next[ADDR_W-1:0];
                                end
                            end

                            if ((r_state == S_DATA) && (r_cnt == c_FRAME_LAST)
                                && w_rx_next[FRAME_W-1]) begin
                                r_wr    <= 1'b1;
                                r_addr  <= w_rx_next[FRAME_W-2:DATA_W];
                                r_wdata <= w_rx_next[DATA_W-1:0];
                            end
                        end

                        // Read data goes out MSB first on the falling edges
                        // of the data phase; MISO is low otherwise
                        if ((r_state == S_DATA) && w_sck_fall) begin
                            if (r_is_read && (r_cnt < c_FRAME_LEN)) begin
                                r_miso <= r_tx[DATA_W-1];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end else begin
                                r_miso <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign spi_miso_o  = r_miso;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_wr_o    = r_wr;
    assign reg_rd_o    = r_rd;
    assign frame_err_o = r_err;

endmodule : w_icons_spi_slave
`default_nettype wire
